// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared external ALU.
// One transaction in flight: IDLE (grant/accept) -> EXEC (drive ALU) -> RESP (hold result).
module alu_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [5:0]         req_op,
    input  logic [2*WIDTH-1:0] req_a,
    input  logic [2*WIDTH-1:0] req_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [WIDTH-1:0]   rsp_result,
    output logic               rsp_carry,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [2:0]         alu_sel,
    input  logic [WIDTH-1:0]   alu_out,
    input  logic               alu_carry
);

    // state | meaning
    // IDLE  | grant one valid requester, latch its operands on accept
    // EXEC  | latched operands on the ALU port, result captured at end of cycle
    // RESP  | rsp_valid high, result held until rsp_ready
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t             state_q, state_d;
    logic               ptr_q, ptr_d;
    logic               id_q;
    logic [WIDTH-1:0]   alu_a_q, alu_b_q;
    logic [2:0]         alu_sel_q;
    logic [WIDTH-1:0]   result_q;
    logic               carry_q;

    logic               grant_id;
    logic               accept;
    logic [2:0]         grant_op;
    logic [WIDTH-1:0]   grant_a, grant_b;

    assign grant_op = grant_id ? req_op[5:3] : req_op[2:0];
    assign grant_a  = grant_id ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
    assign grant_b  = grant_id ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        req_ready = 2'b00;
        accept    = 1'b0;
        grant_id  = ptr_q;
        case (state_q)
            IDLE: begin
                // A lone requester wins outright; the pointer only breaks ties.
                case (req_valid)
                    2'b01:   grant_id = 1'b0;
                    2'b10:   grant_id = 1'b1;
                    default: grant_id = ptr_q;
                endcase
                if (!rst && (req_valid != 2'b00)) begin
                    req_ready = grant_id ? 2'b10 : 2'b01;
                    accept    = 1'b1;
                    ptr_d     = ~grant_id;
                    state_d   = EXEC;
                end
            end
            EXEC: state_d = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= 1'b0;
            id_q      <= 1'b0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_sel_q <= 3'b000;
            result_q  <= '0;
            carry_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            // The ALU port registers double as the operand latch, so they only move on accept.
            if (accept) begin
                id_q      <= grant_id;
                alu_a_q   <= grant_a;
                alu_b_q   <= grant_b;
                alu_sel_q <= grant_op;
            end
            if (state_q == EXEC) begin
                result_q <= alu_out;
                carry_q  <= (alu_sel_q[2:1] == 2'b00) & alu_carry;
            end
        end
    end

    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = id_q;
    assign rsp_result = result_q;
    assign rsp_carry  = carry_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_sel    = alu_sel_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: external ALU stub, transaction-level reference model checked
// every cycle, plus directed sequences with hand-computed literal expectations.
module tb_alu_arbiter;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [5:0]     req_op;
    logic [2*W-1:0] req_a, req_b;
    logic           rsp_valid, rsp_ready, rsp_id;
    logic [W-1:0]   rsp_result;
    logic           rsp_carry;
    logic [W-1:0]   alu_a, alu_b, alu_out;
    logic [2:0]     alu_sel;
    logic           alu_carry;
    logic           force_carry;
    logic [W:0]     alu_raw;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_carry(alu_carry)
    );

    function automatic logic [W:0] spec_alu(input logic [2:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        logic [W-1:0] t;
        case (op)
            3'd0: return {1'b0, a} + {1'b0, b};
            3'd1: return {1'b0, a} - {1'b0, b};
            3'd2: return {1'b0, a & b};
            3'd3: return {1'b0, a | b};
            3'd4: return {1'b0, a ^ b};
            3'd5: return {1'b0, ~a};
            3'd6: begin t = a << 1; return {1'b0, t}; end
            default: begin t = a >> 1; return {1'b0, t}; end
        endcase
    endfunction

    always_comb alu_raw = spec_alu(alu_sel, alu_a, alu_b);
    assign alu_out   = alu_raw[W-1:0];
    assign alu_carry = alu_raw[W] | force_carry;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // Reference model: at most one transaction in flight, aged by cycles since accept.
    logic         m_init = 1'b0;
    logic         m_ptr, m_busy, m_age;
    logic         m_id, m_carry;
    logic [W-1:0] m_res, m_alu_a, m_alu_b;
    logic [2:0]   m_alu_sel;

    always @(negedge clk) begin
        logic [1:0]   e_ready;
        logic         w;
        logic [2:0]   op;
        logic [W-1:0] a, b;
        logic [W:0]   r;
        e_ready = 2'b00;
        w = 1'b0;
        if (!rst && m_init && !m_busy && req_valid != 2'b00) begin
            w = (req_valid == 2'b11) ? m_ptr : req_valid[1];
            e_ready = w ? 2'b10 : 2'b01;
        end
        if (m_init) begin
            chk("mon_req_ready", req_ready, e_ready);
            chk("mon_rsp_valid", rsp_valid, m_busy && m_age);
            chk("mon_alu_a", alu_a, m_alu_a);
            chk("mon_alu_b", alu_b, m_alu_b);
            chk("mon_alu_sel", alu_sel, m_alu_sel);
            if (m_busy && m_age) begin
                chk("mon_rsp_id", rsp_id, m_id);
                chk("mon_rsp_result", rsp_result, m_res);
                chk("mon_rsp_carry", rsp_carry, m_carry);
            end
        end
        if (rst) begin
            m_init = 1'b1; m_ptr = 1'b0; m_busy = 1'b0; m_age = 1'b0;
            m_alu_a = '0; m_alu_b = '0; m_alu_sel = 3'b000;
        end else if (m_init) begin
            if (!m_busy) begin
                if (e_ready != 2'b00) begin
                    op = w ? req_op[5:3] : req_op[2:0];
                    a  = w ? req_a[2*W-1:W] : req_a[W-1:0];
                    b  = w ? req_b[2*W-1:W] : req_b[W-1:0];
                    r  = spec_alu(op, a, b);
                    m_id = w; m_res = r[W-1:0];
                    m_carry = (op == 3'd0 || op == 3'd1) ? r[W] : 1'b0;
                    m_alu_a = a; m_alu_b = b; m_alu_sel = op;
                    m_ptr = ~w; m_busy = 1'b1; m_age = 1'b0;
                end
            end else if (!m_age) begin
                m_age = 1'b1;
            end else if (rsp_ready) begin
                m_busy = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 8; i++) begin
            if (req_ready != 2'b00) return;
            step();
        end
        n_total++;
        $display("FAIL wait_ready: got timeout expected a grant within 8 cycles");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 2'b11; req_op = '0; req_a = '0; req_b = '0;
        rsp_ready = 1'b1; force_carry = 1'b0;
        step(); step(); #1;
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_rsp_carry", rsp_carry, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_sel", alu_sel, 0);

        // Single add 9+8
        rst = 1'b0; req_valid = 2'b01; req_op = 6'b000_000;
        req_a = {4'h0, 4'h9}; req_b = {4'h0, 4'h8}; #1;
        chk("t1_ready", req_ready, 2'b01);
        step(); req_valid = 2'b00; #1;
        chk("t1_exec_ready", req_ready, 2'b00);
        chk("t1_exec_valid", rsp_valid, 0);
        chk("t1_exec_alu_a", alu_a, 4'h9);
        step(); #1;
        chk("t1_rsp_valid", rsp_valid, 1);
        chk("t1_rsp_id", rsp_id, 0);
        chk("t1_result", rsp_result, 4'h1);
        chk("t1_carry", rsp_carry, 1);
        step(); #1;
        chk("t1_idle", rsp_valid, 0);

        // Contention from reset: grants alternate 0,1,0,1,0,1
        rst = 1'b1; step(); rst = 1'b0;
        req_valid = 2'b11; req_op = 6'b010_000;
        req_a = {4'hC, 4'h1}; req_b = {4'hA, 4'h2}; #1;
        for (int k = 0; k < 6; k++) begin
            wait_ready();
            chk("t2_grant", req_ready, (k % 2 == 1) ? 2'b10 : 2'b01);
            step(); step(); #1;
            chk("t2_rsp_id", rsp_id, k % 2);
            if (k == 1) begin
                chk("t2_and_result", rsp_result, 4'h8);
                chk("t2_and_carry", rsp_carry, 0);
            end
            step();
        end

        // Backpressure with shl1 of 5
        req_valid = 2'b01; req_op = 6'b000_110; req_a = {4'h0, 4'h5}; req_b = '0;
        rsp_ready = 1'b0; #1;
        wait_ready();
        chk("t3_ready", req_ready, 2'b01);
        step(); req_valid = 2'b00; step(); req_valid = 2'b11;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t3_hold_valid", rsp_valid, 1);
            chk("t3_hold_result", rsp_result, 4'hA);
            chk("t3_hold_ready", req_ready, 2'b00);
            step();
        end
        rsp_ready = 1'b1; #1;
        chk("t3_last_valid", rsp_valid, 1);
        step(); #1;
        chk("t3_idle_valid", rsp_valid, 0);
        chk("t3_idle_ready", req_ready, 2'b10);
        req_valid = 2'b00; step();

        // Sub borrow, then OR with carry forced high
        req_valid = 2'b10; req_op = 6'b001_000; req_a = {4'h2, 4'h0}; req_b = {4'h3, 4'h0}; #1;
        chk("t4_ready", req_ready, 2'b10);
        step(); req_valid = 2'b00; step(); #1;
        chk("t4_sub_result", rsp_result, 4'hF);
        chk("t4_sub_carry", rsp_carry, 1);
        chk("t4_sub_id", rsp_id, 1);
        step();
        force_carry = 1'b1; req_valid = 2'b01; req_op = 6'b000_011;
        req_a = {4'h0, 4'h3}; req_b = {4'h0, 4'h4}; #1;
        chk("t4_or_ready", req_ready, 2'b01);
        step(); req_valid = 2'b00; step(); #1;
        chk("t4_or_result", rsp_result, 4'h7);
        chk("t4_or_carry", rsp_carry, 0);
        force_carry = 1'b0; step();

        // Reset during EXEC after pointer has moved to 0
        req_valid = 2'b10; req_op = 6'b000_000; req_a = {4'h7, 4'h0}; req_b = '0; #1;
        chk("t5_ready", req_ready, 2'b10);
        step(); req_valid = 2'b00; rst = 1'b1; #1;
        chk("t5_exec_valid", rsp_valid, 0);
        chk("t5_rst_ready", req_ready, 2'b00);
        step(); rst = 1'b0; #1;
        chk("t5_after_valid", rsp_valid, 0);
        chk("t5_after_alu_a", alu_a, 0);
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            chk("t5_no_rsp", rsp_valid, 0);
        end
        req_valid = 2'b11; #1;
        chk("t5_ptr_reset", req_ready, 2'b01);

        // Requests withdrawn before an edge neither win nor move the pointer
        req_valid = 2'b00; step();
        req_valid = 2'b10; #1;
        chk("t6_single", req_ready, 2'b10);
        req_valid = 2'b00; step();
        req_valid = 2'b11; #1;
        chk("t6_ptr_kept", req_ready, 2'b01);
        req_valid = 2'b00; step(); step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
